instruction_memory_loadable: RTL and testbench
==============================================

Name: instruction_memory_loadable

Overview:
- Parametrised, synchronous-read instruction memory for the 8-bit nibble CPU family.
- Replaces hard-coded program ROMs: the program is streamed in at run time through a valid/ready load port, so one block serves every program.
- Sits between the program loader/testbench and the CPU fetch stage.
- Fills itself with FILL_VALUE after reset, blocks fetches while loading, and reports completion.

Parameters:
ADDR_WIDTH, 5, fetch and load address width
DATA_WIDTH, 8, instruction word width
DEPTH, 32, number of implemented words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH
FILL_VALUE, 0, word written during clear and returned for out-of-range fetches

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst  in  1  asynchronous, active-high reset
address  in  ADDR_WIDTH  fetch address
fetch_en  in  1  fetch request
data  out  DATA_WIDTH  registered instruction word
data_valid  out  1  data carries the result of the previous cycle's fetch
load_start  in  1  start a program load (single-cycle pulse)
load_valid  in  1  load_data is valid
load_data  in  DATA_WIDTH  program word
load_last  in  1  qualifies the final word of a load
load_ready  out  1  block accepts a load word this cycle
load_done  out  1  one-cycle pulse when a load completes
load_count  out  ADDR_WIDTH+1  number of words written by the last load
busy  out  1  high in CLEAR or LOAD

Behaviour:
- Reset (asynchronous, any state including mid-load):
  - state=CLEAR, clear pointer=0.
  - Outputs: data=FILL_VALUE, data_valid=0, load_ready=0, load_done=0, load_count=0, busy=1.
- CLEAR:
  - Writes FILL_VALUE to mem[ptr] each cycle, ptr++.
  - After mem[DEPTH-1] is written, goes to RUN next cycle; CLEAR lasts exactly DEPTH cycles.
  - fetch_en, load_start and load_valid are ignored. data_valid=0, data holds its value.
- RUN:
  - busy=0, load_ready=0.
  - fetch_en=1 in cycle N -> in cycle N+1, data=mem[address] if address<DEPTH, else FILL_VALUE, and data_valid=1.
  - fetch_en=0 -> data_valid=0 next cycle; data holds its value.
  - load_start=1 -> LOAD next cycle, load pointer=0.
  - fetch_en and load_start together: the fetch is still serviced (data_valid=1 next cycle), then LOAD.
- LOAD:
  - load_ready=1, busy=1.
  - Transfer occurs when load_valid && load_ready: mem[ptr]=load_data, ptr++.
  - Load ends on a transfer with load_last=1, or on the transfer that writes index DEPTH-1 (load_last then ignored).
  - At end: load_ready=0 from the next cycle, load_done=1 for exactly one cycle, load_count=number of words written (1..DEPTH), return to RUN.
  - load_count holds until the next load ends or reset.
  - Words not written during a load keep their prior contents.
  - fetch_en is ignored (data_valid=0, data holds). load_start is ignored.
  - load_valid=0 stalls the load indefinitely with no timeout.
- The first fetch is possible in the cycle after busy falls.
- load_count width ADDR_WIDTH+1 so that DEPTH=2**ADDR_WIDTH is representable.

Test Plan:
- Reset, defaults -> busy=1 for exactly 32 cycles. Then fetch address 0..31: each returns 8'h00 one cycle later with data_valid=1.
- Load 30 words 8'h3C,8'h00,8'h38,... with load_last on word 30 -> load_done pulses once, load_count=30. Fetching address 29 returns word 30; address 30 returns 8'h00.
- Load with load_valid toggled 1,0,0,1,... and load_last never asserted -> stalls are honoured; load ends after 32 transfers, load_count=32, and load_ready=0 the next cycle.
- DEPTH=20, ADDR_WIDTH=5: fetch address 25 -> data=FILL_VALUE with data_valid=1. Loading 25 words ends after 20 transfers, load_count=20.
- fetch_en asserted during CLEAR and LOAD -> data_valid stays 0 and data does not change. fetch_en with load_start in RUN -> that fetch completes, then load_ready=1.
- rst asserted after 10 load words -> outputs reset immediately; memory is refilled to 8'h00 over 32 cycles, load_count=0, and no load_done pulse occurs.

Source files
------------

// File: rtl/instruction_memory_loadable_if.sv
// Fetch and program-load port bundle for instruction_memory_loadable.
// master: CPU fetch stage / program loader side; slave: the memory.
interface instruction_memory_loadable_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  fetch_en;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_done;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  busy;

  modport master (
    output address, fetch_en, load_start, load_valid, load_data, load_last,
    input  data, data_valid, load_ready, load_done, load_count, busy
  );

  modport slave (
    input  address, fetch_en, load_start, load_valid, load_data, load_last,
    output data, data_valid, load_ready, load_done, load_count, busy
  );
endinterface

// File: rtl/instruction_memory_loadable.sv
// Synchronous-read instruction memory, cleared to FILL_VALUE after reset and
// loaded at run time through a valid/ready stream.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_CLEAR | write FILL_VALUE to every word, one per cycle (DEPTH cycles)
//   S_RUN   | service fetches; load_start moves to S_LOAD
//   S_LOAD  | accept program words until load_last or the last index
module instruction_memory_loadable #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input logic                    clk,
  input logic                    rst,
  instruction_memory_loadable_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   ptr, ptr_nxt;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  xfer;
  logic                  load_end;
  logic                  fetch_ok;
  logic                  in_range;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    we        = 1'b0;
    wdata     = FILL_VALUE;
    xfer      = 1'b0;
    load_end  = 1'b0;
    case (state)
      S_CLEAR: begin
        we      = 1'b1;
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_IDX) begin
          state_nxt = S_RUN;
          ptr_nxt   = '0;
        end
      end
      S_RUN: begin
        if (bus.load_start) begin
          state_nxt = S_LOAD;
          ptr_nxt   = '0;
        end
      end
      S_LOAD: begin
        xfer = bus.load_valid;
        if (xfer) begin
          we      = 1'b1;
          wdata   = bus.load_data;
          ptr_nxt = ptr + 1'b1;
          // Reaching the last implemented word ends the load even without load_last
          if (bus.load_last || ptr == LAST_IDX) begin
            load_end  = 1'b1;
            state_nxt = S_RUN;
          end
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Storage array is deliberately not reset; S_CLEAR initialises it
  always_ff @(posedge clk) begin
    if (we) mem[ptr[ADDR_WIDTH-1:0]] <= wdata;
  end

  assign fetch_ok = (state == S_RUN) && bus.fetch_en;
  assign in_range = {1'b0, bus.address} < DEPTH_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data       <= FILL_VALUE;
      bus.data_valid <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.load_count <= '0;
    end else begin
      bus.data_valid <= fetch_ok;
      if (fetch_ok) bus.data <= in_range ? mem[bus.address] : FILL_VALUE;
      bus.load_done <= load_end;
      if (load_end) bus.load_count <= ptr + 1'b1;
    end
  end

  assign bus.load_ready = (state == S_LOAD);
  assign bus.busy       = (state != S_RUN);

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench for instruction_memory_loadable: a DEPTH=32 instance and a
// DEPTH=20 instance with a non-zero fill value share clock and reset.
module tb_instruction_memory_loadable;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_memory_loadable_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) ia ();
  instruction_memory_loadable_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) ib ();

  instruction_memory_loadable #(
    .ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(32), .FILL_VALUE(8'h00)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));

  instruction_memory_loadable #(
    .ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(20), .FILL_VALUE(8'hA5)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  typedef struct {
    logic [4:0] addr;
    logic [7:0] exp_data;
  } rd_vec_t;

  rd_vec_t vecs[$];
  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ia.address = '0; ia.fetch_en = 1'b0; ia.load_start = 1'b0;
    ia.load_valid = 1'b0; ia.load_data = '0; ia.load_last = 1'b0;
    ib.address = '0; ib.fetch_en = 1'b0; ib.load_start = 1'b0;
    ib.load_valid = 1'b0; ib.load_data = '0; ib.load_last = 1'b0;
  endtask

  // Apply each fetch vector and compare data/data_valid one cycle later
  task automatic run_vecs(input bit use_b, input string tag);
    logic [7:0] d;
    logic       v;
    foreach (vecs[k]) begin
      if (use_b) begin ib.fetch_en = 1'b1; ib.address = vecs[k].addr; end
      else       begin ia.fetch_en = 1'b1; ia.address = vecs[k].addr; end
      tick();
      d = use_b ? ib.data : ia.data;
      v = use_b ? ib.data_valid : ia.data_valid;
      check($sformatf("%s data[%0d]", tag, vecs[k].addr), 32'(d), 32'(vecs[k].exp_data));
      check($sformatf("%s valid[%0d]", tag, vecs[k].addr), 32'(v), 32'd1);
    end
    ia.fetch_en = 1'b0;
    ib.fetch_en = 1'b0;
  endtask

  // Called right after rst falls; counts rising edges until busy drops on dut_a
  task automatic wait_clear(output int cyc, output int dv_bad, output int data_bad,
                            output int done_seen);
    logic [7:0] d0;
    d0 = ia.data;
    cyc = 0; dv_bad = 0; data_bad = 0; done_seen = 0;
    while (ia.busy && cyc < 100) begin
      tick();
      cyc++;
      if (ia.data_valid) dv_bad++;
      if (ia.data !== d0) data_bad++;
      if (ia.load_done) done_seen++;
    end
  endtask

  function automatic logic [7:0] word30(input int i);
    return (i % 2 == 0) ? 8'(60 - 2 * i) : 8'((i - 1) * 8);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dv_bad, data_bad, done_seen, early, ready_bad, xf;
    logic v;

    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst busy", 32'(ia.busy), 32'd1);
    check("rst data", 32'(ia.data), 32'h00);
    check("rst data_valid", 32'(ia.data_valid), 32'd0);
    check("rst load_ready", 32'(ia.load_ready), 32'd0);
    check("rst load_done", 32'(ia.load_done), 32'd0);
    check("rst load_count", 32'(ia.load_count), 32'd0);
    check("rst b data", 32'(ib.data), 32'hA5);

    // Fetches during CLEAR must be ignored
    rst = 1'b0;
    ia.fetch_en = 1'b1; ia.address = 5'd3;
    wait_clear(cyc, dv_bad, data_bad, done_seen);
    check("clear busy cycles", 32'(cyc), 32'd32);
    check("clear data_valid", 32'(dv_bad), 32'd0);
    check("clear data held", 32'(data_bad), 32'd0);
    ia.fetch_en = 1'b0;

    vecs.delete();
    for (int i = 0; i < 32; i++) vecs.push_back('{addr: 5'(i), exp_data: 8'h00});
    run_vecs(1'b0, "post-clear");
    tick();
    check("idle data_valid", 32'(ia.data_valid), 32'd0);
    check("idle data held", 32'(ia.data), 32'h00);

    // Fetch together with load_start: the fetch completes, then LOAD
    ia.fetch_en = 1'b1; ia.address = 5'd5; ia.load_start = 1'b1;
    tick();
    check("start fetch valid", 32'(ia.data_valid), 32'd1);
    check("start fetch data", 32'(ia.data), 32'h00);
    check("start load_ready", 32'(ia.load_ready), 32'd1);
    check("start busy", 32'(ia.busy), 32'd1);
    ia.load_start = 1'b0; ia.address = 5'd7;

    dv_bad = 0; early = 0; ready_bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (!ia.load_ready) ready_bad++;
      ia.load_valid = 1'b1; ia.load_data = word30(i); ia.load_last = (i == 29);
      tick();
      if (ia.data_valid) dv_bad++;
      if (ia.load_done && i < 29) early++;
    end
    check("load30 fetch ignored", 32'(dv_bad), 32'd0);
    check("load30 ready", 32'(ready_bad), 32'd0);
    check("load30 early done", 32'(early), 32'd0);
    check("load30 done", 32'(ia.load_done), 32'd1);
    check("load30 ready off", 32'(ia.load_ready), 32'd0);
    check("load30 count", 32'(ia.load_count), 32'd30);
    check("load30 data held", 32'(ia.data), 32'h00);
    idle_inputs();
    tick();
    check("load30 done pulse", 32'(ia.load_done), 32'd0);
    check("load30 count hold", 32'(ia.load_count), 32'd30);

    vecs.delete();
    vecs.push_back('{addr: 5'd0,  exp_data: 8'h3C});
    vecs.push_back('{addr: 5'd1,  exp_data: 8'h00});
    vecs.push_back('{addr: 5'd2,  exp_data: 8'h38});
    vecs.push_back('{addr: 5'd3,  exp_data: 8'h10});
    vecs.push_back('{addr: 5'd28, exp_data: 8'h04});
    vecs.push_back('{addr: 5'd29, exp_data: 8'hE0});
    vecs.push_back('{addr: 5'd30, exp_data: 8'h00});
    vecs.push_back('{addr: 5'd31, exp_data: 8'h00});
    run_vecs(1'b0, "load30");

    // Stalled load without load_last: valid pattern 1,0,0,1,0,0,...
    ia.load_start = 1'b1;
    tick();
    ia.load_start = 1'b0;
    xf = 0; cyc = 0; early = 0; ready_bad = 0;
    while (xf < 32 && cyc < 200) begin
      v = (cyc % 3 == 0);
      if (!ia.load_ready) ready_bad++;
      ia.load_valid = v; ia.load_data = 8'(8'h40 + xf); ia.load_last = 1'b0;
      if (v && ia.load_ready) xf++;
      tick();
      cyc++;
      if (xf < 32 && ia.load_done) early++;
    end
    check("load32 transfers", 32'(xf), 32'd32);
    check("load32 cycles", 32'(cyc), 32'd94);
    check("load32 ready", 32'(ready_bad), 32'd0);
    check("load32 early done", 32'(early), 32'd0);
    check("load32 done", 32'(ia.load_done), 32'd1);
    check("load32 ready off", 32'(ia.load_ready), 32'd0);
    check("load32 count", 32'(ia.load_count), 32'd32);
    idle_inputs();
    tick();

    vecs.delete();
    vecs.push_back('{addr: 5'd0,  exp_data: 8'h40});
    vecs.push_back('{addr: 5'd17, exp_data: 8'h51});
    vecs.push_back('{addr: 5'd29, exp_data: 8'h5D});
    vecs.push_back('{addr: 5'd31, exp_data: 8'h5F});
    run_vecs(1'b0, "load32");

    // Reset in the middle of a load
    ia.load_start = 1'b1;
    tick();
    ia.load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ia.load_valid = 1'b1; ia.load_data = 8'hEE; ia.load_last = 1'b0;
      tick();
    end
    rst = 1'b1;
    #1;
    check("midrst data", 32'(ia.data), 32'h00);
    check("midrst busy", 32'(ia.busy), 32'd1);
    check("midrst load_ready", 32'(ia.load_ready), 32'd0);
    check("midrst load_count", 32'(ia.load_count), 32'd0);
    check("midrst load_done", 32'(ia.load_done), 32'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    wait_clear(cyc, dv_bad, data_bad, done_seen);
    check("midrst busy cycles", 32'(cyc), 32'd32);
    check("midrst no done", 32'(done_seen), 32'd0);
    check("midrst count", 32'(ia.load_count), 32'd0);
    vecs.delete();
    for (int i = 0; i < 32; i++) vecs.push_back('{addr: 5'(i), exp_data: 8'h00});
    run_vecs(1'b0, "midrst");

    // DEPTH=20 instance: out-of-range fetch and truncated load
    vecs.delete();
    vecs.push_back('{addr: 5'd25, exp_data: 8'hA5});
    vecs.push_back('{addr: 5'd3,  exp_data: 8'hA5});
    run_vecs(1'b1, "d20 pre");
    ib.load_start = 1'b1;
    tick();
    ib.load_start = 1'b0;
    xf = 0; done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      ib.load_valid = 1'b1; ib.load_data = 8'(8'h10 + i); ib.load_last = (i == 24);
      if (ib.load_ready) xf++;
      tick();
      if (ib.load_done) done_seen++;
    end
    check("d20 transfers", 32'(xf), 32'd20);
    check("d20 done pulses", 32'(done_seen), 32'd1);
    check("d20 count", 32'(ib.load_count), 32'd20);
    check("d20 ready off", 32'(ib.load_ready), 32'd0);
    idle_inputs();
    tick();
    vecs.delete();
    vecs.push_back('{addr: 5'd0,  exp_data: 8'h10});
    vecs.push_back('{addr: 5'd19, exp_data: 8'h23});
    vecs.push_back('{addr: 5'd20, exp_data: 8'hA5});
    vecs.push_back('{addr: 5'd25, exp_data: 8'hA5});
    vecs.push_back('{addr: 5'd31, exp_data: 8'hA5});
    run_vecs(1'b1, "d20 post");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
